// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner:
// segment patterns (g..a, active-low) and the leading-zero mask function.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ALL   = 7'b0000000;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

    // Bit i set when nibbles num_digits-1 down to i are all zero; bit 0 never set.
    function automatic logic [7:0] lz_mask(input logic [31:0] data, input int num_digits);
        logic above_zero;
        lz_mask    = '0;
        above_zero = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (i < num_digits) begin
                above_zero = above_zero & (data[4*i +: 4] == 4'h0);
                lz_mask[i] = above_zero;
            end
        end
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Generic modulo-N counter with a combinational terminal-count pulse,
// advancing only when en is high.
module seg7_prescaler #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (en) begin
            cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;
    assign tc  = en && (cnt_reg == LAST);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver with dead gap, leading-zero
// suppression and blank/test. Define SEG7_BLINK_EN to add per-digit blinking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank,
    input  logic                    test,
    input  logic                    lz_en,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              display,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_cfg
            $error("seg7_scan: illegal parameter set");
        end
    endgenerate

    logic [4*NUM_DIGITS-1:0] shadow_data_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [CNT_W-1:0]        cnt;
    logic                    slot_tc;

    logic [6:0]              display_reg, display_next;
    logic                    dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]   digit_sel_reg, digit_sel_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
        end else if (load) begin
            shadow_data_reg <= data;
            shadow_dp_reg   <= dp_in;
        end
    end

    seg7_prescaler #(
        .N (SCAN_DIV),
        .W (CNT_W)
    ) u_slot (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .cnt   (cnt),
        .tc    (slot_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg <= '0;
        end else if (slot_tc) begin
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    logic blink_dark;

`ifdef SEG7_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_tc;
    logic               round_end;
    logic               phase_reg;

    // One blink count per completed scan round.
    assign round_end = slot_tc && (idx_reg == IDX_LAST);

    seg7_prescaler #(
        .N (BLINK_DIV),
        .W (BLINK_W)
    ) u_blink (
        .clk   (clk),
        .reset (reset),
        .en    (round_end),
        .cnt   (blink_cnt),
        .tc    (blink_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg <= 1'b0;
        end else if (blink_tc) begin
            phase_reg <= ~phase_reg;
        end
    end

    assign blink_dark = phase_reg && blink_mask[idx_reg];
`else
    assign blink_dark = 1'b0;
`endif

    // Per-digit views of the shadow register, selected by the scan index.
    logic [3:0]            nib_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [7:0]            lz_all;
    logic [NUM_DIGITS-1:0] lz_vec;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib_arr[gi]    = shadow_data_reg[4*gi +: 4];
            assign sel_onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign lz_all = lz_mask(32'(shadow_data_reg), NUM_DIGITS);
    assign lz_vec = lz_all[NUM_DIGITS-1:0];

    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       lz_dark;

    assign cur_nib = nib_arr[idx_reg];
    assign cur_dp  = shadow_dp_reg[idx_reg];
    // A lit decimal point keeps an otherwise leading-zero digit visible.
    assign lz_dark = lz_en && lz_vec[idx_reg] && !cur_dp;

    always_comb begin
        digit_sel_next = '1;
        display_next   = SEG_BLANK;
        dp_next        = 1'b1;
        if (!((cnt == '0) || blank || blink_dark)) begin
            digit_sel_next = ~sel_onehot;
            if (test) begin
                display_next = SEG_ALL;
                dp_next      = 1'b0;
            end else if (!lz_dark) begin
                display_next = hex_to_seg(cur_nib);
                dp_next      = ~cur_dp;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_reg   <= SEG_BLANK;
            dp_reg        <= 1'b1;
            digit_sel_reg <= '1;
        end else begin
            display_reg   <= display_next;
            dp_reg        <= dp_next;
            digit_sel_reg <= digit_sel_next;
        end
    end

    assign display   = display_reg;
    assign dp        = dp_reg;
    assign digit_sel = digit_sel_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: table vectors, hand-written corner sequences and
// randomized traffic checked every cycle against a time-based reference model.
module tb_seg7_scan;

    localparam int ND = 4;
    localparam int S  = 4;
    localparam int B  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        load, blank, test, lz_en;
`ifdef SEG7_BLINK_EN
    logic [3:0]  blink_mask;
`endif
    logic [6:0]  display;
    logic        dp;
    logic [3:0]  digit_sel;

    seg7_scan #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (S),
        .BLINK_DIV  (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .dp_in      (dp_in),
        .load       (load),
        .blank      (blank),
        .test       (test),
        .lz_en      (lz_en),
`ifdef SEG7_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .display    (display),
        .dp         (dp),
        .digit_sel  (digit_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: edges since reset release and the model's copy of the shadow.
    int          k;
    logic [15:0] m_data;
    logic [3:0]  m_dp;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected {digit_sel, display, dp} for the coming edge.
    function automatic logic [11:0] expect_out();
        int   cnt, idx;
        logic [3:0] sel;
        cnt = k % S;
        idx = (k / S) % ND;
        if (reset) return {4'hF, 7'h7F, 1'b1};
        if (cnt == 0 || blank) return {4'hF, 7'h7F, 1'b1};
`ifdef SEG7_BLINK_EN
        if (((k / (S * ND * B)) % 2 == 1) && blink_mask[idx]) return {4'hF, 7'h7F, 1'b1};
`endif
        sel = ~(4'b0001 << idx);
        if (test) return {sel, 7'h00, 1'b0};
        if (lz_en && idx > 0 && ((m_data >> (4 * idx)) == 16'h0) && !m_dp[idx])
            return {sel, 7'h7F, 1'b1};
        return {sel, HEX[m_data[4*idx +: 4]], ~m_dp[idx]};
    endfunction

    task automatic tick();
        logic [11:0] exp;
        @(posedge clk);
        exp = expect_out();
        if (reset) begin
            k = 0; m_data = '0; m_dp = '0;
        end else begin
            if (load) begin m_data = data; m_dp = dp_in; end
            k++;
        end
        #1;
        chk("model", {20'h0, digit_sel, display, dp}, {20'h0, exp});
    endtask

    task automatic wait_state(input int c, input int i);
        bit ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (k % S == c && (k / S) % ND == i) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) chk("wait_state timeout", 0, 1);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  dpv;
        logic        lz;
        int          digit;
        logic [6:0]  disp;
        logic        dpo;
    } vec_t;

    vec_t vt [14];

    initial begin
        logic [3:0] esel;
        logic [15:0] masks [4];
        bit found;
        int lit0, lit1;

        vt[0]  = '{16'h12AF, 4'b0000, 1'b0, 0, 7'b0001110, 1'b1};
        vt[1]  = '{16'h12AF, 4'b0000, 1'b0, 1, 7'b0001000, 1'b1};
        vt[2]  = '{16'h12AF, 4'b0000, 1'b0, 2, 7'b0100100, 1'b1};
        vt[3]  = '{16'h12AF, 4'b0000, 1'b0, 3, 7'b1111001, 1'b1};
        vt[4]  = '{16'h0050, 4'b0000, 1'b1, 3, 7'b1111111, 1'b1};
        vt[5]  = '{16'h0050, 4'b0000, 1'b1, 2, 7'b1111111, 1'b1};
        vt[6]  = '{16'h0050, 4'b0000, 1'b1, 1, 7'b0010010, 1'b1};
        vt[7]  = '{16'h0050, 4'b0000, 1'b1, 0, 7'b1000000, 1'b1};
        vt[8]  = '{16'h0000, 4'b0000, 1'b1, 0, 7'b1000000, 1'b1};
        vt[9]  = '{16'h0000, 4'b0000, 1'b1, 1, 7'b1111111, 1'b1};
        vt[10] = '{16'h0000, 4'b0100, 1'b1, 2, 7'b1000000, 1'b0};
        vt[11] = '{16'h0000, 4'b0100, 1'b1, 3, 7'b1111111, 1'b1};
        vt[12] = '{16'h0050, 4'b0000, 1'b0, 3, 7'b1000000, 1'b1};
        vt[13] = '{16'h0008, 4'b0001, 1'b0, 0, 7'b0000000, 1'b0};

        reset = 1'b1; data = '0; dp_in = '0; load = 1'b0;
        blank = 1'b0; test = 1'b0; lz_en = 1'b0;
`ifdef SEG7_BLINK_EN
        blink_mask = '0;
`endif
        k = 0; m_data = '0; m_dp = '0;

        // Reset state and first edges after release.
        #2;
        chk("reset state", {20'h0, digit_sel, display, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("first edge gap", {28'h0, digit_sel}, 32'hF);
        tick();
        chk("second edge digit0", {28'h0, digit_sel}, 32'hE);

        // Static images from the vector table.
        for (int i = 0; i < 14; i++) begin
            data = vt[i].d; dp_in = vt[i].dpv; lz_en = vt[i].lz; load = 1'b1;
            tick();
            load = 1'b0;
            esel = ~(4'b0001 << vt[i].digit);
            found = 1'b0;
            for (int n = 0; n < 40; n++) begin
                tick();
                if (digit_sel == esel) begin found = 1'b1; break; end
            end
            if (!found) begin
                chk($sformatf("vec%0d sel timeout", i), {28'h0, digit_sel}, {28'h0, esel});
            end else begin
                chk($sformatf("vec%0d display", i), {25'h0, display}, {25'h0, vt[i].disp});
                chk($sformatf("vec%0d dp", i), {31'h0, dp}, {31'h0, vt[i].dpo});
            end
        end

        // Lamp test, then blank overriding test; the model tracks scan phase across both.
        lz_en = 1'b0;
        test = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("test pattern", {24'h0, display, dp},
                ((k - 1) % S == 0) ? {24'h0, 7'h7F, 1'b1} : 32'h0);
        end
        blank = 1'b1;
        repeat (5) tick();
        chk("blank over test", {20'h0, digit_sel, display, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
        blank = 1'b0; test = 1'b0;
        repeat (S * ND) tick();

        // Load in the middle of digit 1's slot: new nibble shows on the next edge.
        data = 16'h0000; load = 1'b1; tick(); load = 1'b0;
        wait_state(2, 1);
        data = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("midslot load display", {25'h0, display}, {25'h0, 7'b0110000});
        chk("midslot load sel", {28'h0, digit_sel}, {28'h0, 4'b1101});

        // Asynchronous reset during digit 2.
        wait_state(2, 2);
        chk("pre-reset sel", {28'h0, digit_sel}, {28'h0, 4'b1011});
        #2 reset = 1'b1;
        #1;
        chk("async reset dark", {20'h0, digit_sel, display, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("post-reset gap", {28'h0, digit_sel}, 32'hF);
        tick();
        chk("post-reset digit0", {28'h0, digit_sel}, 32'hE);

        // Randomized traffic against the model.
        masks[0] = 16'hFFFF; masks[1] = 16'h00FF; masks[2] = 16'h000F; masks[3] = 16'h0000;
        for (int n = 0; n < 800; n++) begin
            blank = ($urandom % 16 == 0);
            test  = ($urandom % 12 == 0);
            load  = ($urandom % 6 == 0);
            lz_en = $urandom % 2;
            data  = 16'($urandom) & masks[$urandom % 4];
            dp_in = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
`ifdef SEG7_BLINK_EN
            blink_mask = 4'($urandom);
`endif
            tick();
        end
        blank = 1'b0; test = 1'b0; load = 1'b0; lz_en = 1'b0;

`ifdef SEG7_BLINK_EN
        // Blink on digit 0 only: two rounds lit, two rounds dark, repeating.
        blink_mask = 4'b0001;
        reset = 1'b1; tick(); reset = 1'b0;
        data = 16'h12AF; dp_in = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int r = 0; r < 3; r++) begin
            lit0 = 0; lit1 = 0;
            for (int n = (r == 0) ? 1 : 0; n < 2 * S * ND; n++) begin
                tick();
                if (digit_sel == 4'b1110 && display != 7'h7F) lit0++;
                if (digit_sel == 4'b1101 && display != 7'h7F) lit1++;
            end
            chk($sformatf("blink digit0 lit cycles window%0d", r), lit0, (r == 1) ? 0 : 2 * (S - 1));
            chk($sformatf("blink digit1 lit cycles window%0d", r), lit1, 2 * (S - 1));
        end
        blink_mask = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
